// File: rtl/d5m_pkg.sv
// Shared types and constants for the D5M camera stream generator.
// The state and pattern encodings are used by the timing FSM and by the pixel source.
package d5m_pkg;

    localparam int DATA_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        FV_LEAD,
        LINE,
        HBLANK,
        FV_TRAIL,
        VBLANK
    } state_e;

    typedef enum logic [1:0] {
        RAMP_X,
        RAMP_Y,
        CHECKER,
        FRAME_ID
    } pattern_e;

    // Counter width for a count of 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/d5m_pattern_src.sv
// Combinational pixel-value generator for the selected test pattern.
// The frame id input carries only the low nibble of the frame counter.
module d5m_pattern_src
    import d5m_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [1:0]        pattern,
    input  logic [3:0]        frame_cnt,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = '0;
        case (pattern_e'(pattern))
            RAMP_X:   data = x;
            RAMP_Y:   data = y;
            CHECKER:  data = (x[4] ^ y[4]) ? {DATA_W{1'b1}} : '0;
            FRAME_ID: data = {frame_cnt, 8'h00};
            default:  data = '0;
        endcase
    end

endmodule

// File: rtl/d5m_stream_gen.sv
// D5M-style frame/line timing generator driving a test pattern on D5M_D.
// Outputs are registered from the next-state values so they only move on the rising edge.
module d5m_stream_gen
    import d5m_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960,
    parameter int H_BLANK  = 64,
    parameter int V_BLANK  = 16
) (
    input  logic              D5M_PIXCLK,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        pattern_sel,
    output logic [DATA_W-1:0] D5M_D,
    output logic              D5M_FVAL,
    output logic              D5M_LVAL,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam int VB_CLKS = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int X_W     = cnt_width(H_ACTIVE);
    localparam int Y_W     = cnt_width(V_ACTIVE);
    localparam int HB_W    = cnt_width(H_BLANK);
    localparam int VB_W    = cnt_width(VB_CLKS);

    localparam logic [X_W-1:0]  X_LAST  = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(V_ACTIVE - 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(H_BLANK - 1);
    localparam logic [VB_W-1:0] VB_LAST = VB_W'(VB_CLKS - 1);

    state_e            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [HB_W-1:0]   hb_q, hb_d;
    logic [VB_W-1:0]   vb_q, vb_d;
    logic [1:0]        pat_q, pat_d;
    logic              stop_pend_q, stop_pend_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              fval_q, fval_d;
    logic              lval_q, lval_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] pix;

    d5m_pattern_src u_pattern_src (
        .x         (DATA_W'(x_d)),
        .y         (DATA_W'(y_d)),
        .pattern   (pat_d),
        .frame_cnt (frame_cnt_q[3:0]),
        .data      (pix)
    );

    always_ff @(posedge D5M_PIXCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            hb_q        <= '0;
            vb_q        <= '0;
            pat_q       <= '0;
            stop_pend_q <= 1'b0;
            frame_cnt_q <= '0;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hb_q        <= hb_d;
            vb_q        <= vb_d;
            pat_q       <= pat_d;
            stop_pend_q <= stop_pend_d;
            frame_cnt_q <= frame_cnt_d;
            fval_q      <= fval_d;
            lval_q      <= lval_d;
            data_q      <= data_d;
        end
    end

    // A stop seen while busy wins over any start in the same cycle; start is only heard in IDLE.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        hb_d        = hb_q;
        vb_d        = vb_q;
        pat_d       = pat_q;
        frame_cnt_d = frame_cnt_q;
        stop_pend_d = stop_pend_q | (stop & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FV_LEAD;
                    hb_d    = '0;
                    x_d     = '0;
                    y_d     = '0;
                    pat_d   = pattern_sel;
                end
            end
            FV_LEAD: begin
                if (hb_q == HB_LAST) begin
                    state_d = LINE;
                    x_d     = '0;
                end else begin
                    hb_d = hb_q + HB_W'(1);
                end
            end
            LINE: begin
                if (x_q == X_LAST) begin
                    state_d = HBLANK;
                    hb_d    = '0;
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
            HBLANK: begin
                if (hb_q == HB_LAST) begin
                    if (y_q == Y_LAST) begin
                        state_d = FV_TRAIL;
                        hb_d    = '0;
                    end else begin
                        state_d = LINE;
                        x_d     = '0;
                        y_d     = y_q + Y_W'(1);
                    end
                end else begin
                    hb_d = hb_q + HB_W'(1);
                end
            end
            FV_TRAIL: begin
                if (hb_q == HB_LAST) begin
                    state_d     = VBLANK;
                    vb_d        = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    hb_d = hb_q + HB_W'(1);
                end
            end
            VBLANK: begin
                if (vb_q == VB_LAST) begin
                    if (stop_pend_d) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                        x_d         = '0;
                        y_d         = '0;
                        hb_d        = '0;
                        vb_d        = '0;
                    end else begin
                        state_d = FV_LEAD;
                        hb_d    = '0;
                        x_d     = '0;
                        y_d     = '0;
                        pat_d   = pattern_sel;
                    end
                end else begin
                    vb_d = vb_q + VB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fval_d = (state_d == FV_LEAD) || (state_d == LINE) ||
                 (state_d == HBLANK)  || (state_d == FV_TRAIL);
        lval_d = (state_d == LINE);
        data_d = lval_d ? pix : '0;
    end

    assign D5M_D     = data_q;
    assign D5M_FVAL  = fval_q;
    assign D5M_LVAL  = lval_q;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_d5m_stream_gen.sv
// Self-checking bench for d5m_stream_gen: frame-level reference model plus pinned timing points.
// The model expands each frame into a per-clock queue of expected output words.
module tb_d5m_stream_gen;

    localparam int H_ACTIVE = 8;
    localparam int V_ACTIVE = 4;
    localparam int H_BLANK  = 4;
    localparam int V_BLANK  = 2;
    localparam int VB_CLKS  = V_BLANK * (H_ACTIVE + H_BLANK);

    typedef struct packed {
        logic        busy;
        logic        fval;
        logic        lval;
        logic [11:0] d;
        logic [15:0] fc;
    } exp_t;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        start       = 1'b0;
    logic        stop        = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [11:0] d;
    logic        fval;
    logic        lval;
    logic        busy;
    logic [15:0] frame_cnt;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    exp_t        exp_q[$];
    exp_t        m_exp  = '0;
    logic        m_busy = 1'b0;
    logic        m_pend = 1'b0;
    logic [15:0] m_fc   = 16'd0;

    d5m_stream_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_BLANK  (V_BLANK)
    ) dut (
        .D5M_PIXCLK  (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .pattern_sel (pattern_sel),
        .D5M_D       (d),
        .D5M_FVAL    (fval),
        .D5M_LVAL    (lval),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    // Clock and cycle index (cycle n = the period following the n-th edge after reset release).
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %h want %h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t mk(input logic b, input logic f, input logic l,
                                input logic [11:0] dd, input logic [15:0] c);
        return {b, f, l, dd, c};
    endfunction

    function automatic logic [11:0] pix(input logic [1:0] pat, input int x, input int y,
                                        input logic [15:0] fc);
        case (pat)
            2'd0:    return 12'(x);
            2'd1:    return 12'(y);
            2'd2:    return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 12'hFFF : 12'h000;
            default: return {fc[3:0], 8'h00};
        endcase
    endfunction

    // One full frame followed by its vertical blank, one entry per clock.
    task automatic push_frame(input logic [1:0] pat);
        logic [15:0] base;
        base = m_fc;
        repeat (H_BLANK) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, base));
        for (int y = 0; y < V_ACTIVE; y++) begin
            for (int x = 0; x < H_ACTIVE; x++)
                exp_q.push_back(mk(1'b1, 1'b1, 1'b1, pix(pat, x, y, base), base));
            repeat (H_BLANK) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, base));
        end
        repeat (H_BLANK) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 12'h000, base));
        m_fc = base + 16'd1;
        repeat (VB_CLKS) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 12'h000, m_fc));
    endtask

    // Reference model: decides at each edge what the outputs must show afterwards.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_pend = 1'b0;
            m_fc   = 16'd0;
            m_exp  = '0;
        end else begin
            if (m_busy && stop) m_pend = 1'b1;
            if (exp_q.size() == 0) begin
                if (m_busy) begin
                    if (m_pend) begin
                        m_busy = 1'b0;
                        m_pend = 1'b0;
                    end else begin
                        push_frame(pattern_sel);
                    end
                end else if (start) begin
                    push_frame(pattern_sel);
                    m_busy = 1'b1;
                end
            end
            if (exp_q.size() > 0) m_exp = exp_q.pop_front();
            else                  m_exp = mk(1'b0, 1'b0, 1'b0, 12'h000, m_fc);
        end
    end

    // Scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        check("stream", {1'b0, busy, fval, lval, d, frame_cnt}, {1'b0, m_exp});
    end

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                check("wait_cyc_timeout", 32'(cyc), 32'(n));
                break;
            end
        end
    endtask

    task automatic wait_lval(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (lval) break;
        end
        if (i == bound) check("lval_timeout", 32'(lval), 32'd1);
    endtask

    task automatic wait_fval_low(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!fval) break;
        end
        if (i == bound) check("fval_low_timeout", 32'(fval), 32'd0);
    endtask

    task automatic wait_idle(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (i == bound) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic pulse_start(input logic [1:0] pat);
        pattern_sel = pat;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_fval", 32'(fval), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_fc", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;

        // Directed frame timing with pattern 0.
        wait_cyc(10);
        check("idle_fval_c10", 32'(fval), 32'd0);
        pattern_sel = 2'd0;
        start       = 1'b1;
        wait_cyc(11);
        start = 1'b0;
        check("fval_rise_c11", 32'(fval), 32'd1);
        check("lead_lval_c11", 32'(lval), 32'd0);
        check("busy_c11", 32'(busy), 32'd1);
        wait_cyc(14);
        check("lead_lval_c14", 32'(lval), 32'd0);
        wait_cyc(15);
        check("lval_rise_c15", 32'(lval), 32'd1);
        check("d_x0_c15", 32'(d), 32'd0);
        wait_cyc(22);
        check("d_x7_c22", 32'(d), 32'd7);
        wait_cyc(23);
        check("hblank_lval_c23", 32'(lval), 32'd0);
        check("hblank_d_c23", 32'(d), 32'd0);
        wait_cyc(66);
        check("trail_fval_c66", 32'(fval), 32'd1);
        check("trail_fc_c66", 32'(frame_cnt), 32'd0);
        wait_cyc(67);
        check("fval_fall_c67", 32'(fval), 32'd0);
        check("fc_one_c67", 32'(frame_cnt), 32'd1);
        wait_cyc(90);
        check("vblank_end_c90", 32'(fval), 32'd0);
        wait_cyc(91);
        check("next_frame_c91", 32'(fval), 32'd1);
        wait_cyc(96);
        check("f1_ramp_c96", 32'(d), 32'd1);

        // Pattern change mid-frame only takes effect at the next frame.
        wait_cyc(100);
        pattern_sel = 2'd2;
        wait_cyc(108);
        check("f1_still_ramp_c108", 32'(d), 32'd1);
        wait_cyc(176);
        check("f2_checker_lval", 32'(lval), 32'd1);
        check("f2_checker_d", 32'(d), 32'd0);

        // Stop together with start in line 2 of frame 2.
        wait_cyc(200);
        start = 1'b1;
        stop  = 1'b1;
        wait_cyc(201);
        start = 1'b0;
        stop  = 1'b0;
        wait_cyc(227);
        check("f2_fval_fall", 32'(fval), 32'd0);
        check("f2_fc", 32'(frame_cnt), 32'd3);
        wait_cyc(250);
        check("vblank_busy_c250", 32'(busy), 32'd1);
        wait_cyc(251);
        check("stopped_busy_c251", 32'(busy), 32'd0);
        check("stopped_fc_c251", 32'(frame_cnt), 32'd3);
        wait_cyc(280);
        check("stopped_fval_c280", 32'(fval), 32'd0);

        // Randomized start/stop/pattern traffic against the model.
        for (int i = 0; i < 800; i++) begin
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) pattern_sel = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        start = 1'b0;
        pulse_stop();
        wait_idle(300);

        // Asynchronous reset in the middle of an active line.
        pulse_start(2'd0);
        wait_lval(100);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_d", 32'(d), 32'd0);
        check("rst_fval", 32'(fval), 32'd0);
        check("rst_lval", 32'(lval), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fc", 32'(frame_cnt), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(2'd3);
        wait_lval(100);
        check("post_rst_id_d", 32'(d), 32'h000);
        check("post_rst_fc", 32'(frame_cnt), 32'd0);
        wait_fval_low(100);
        check("post_rst_fc_done", 32'(frame_cnt), 32'd1);
        pulse_stop();
        wait_idle(100);

        // Frame counter wrap with the frame-id pattern.
        #2;
        force dut.frame_cnt_q = 16'hFFFF;
        m_fc = 16'hFFFF;
        @(negedge clk);
        check("preset_fc", 32'(frame_cnt), 32'hFFFF);
        release dut.frame_cnt_q;
        pulse_start(2'd3);
        wait_lval(100);
        check("wrap_id_d", 32'(d), 32'hF00);
        wait_fval_low(100);
        check("wrap_fc", 32'(frame_cnt), 32'd0);
        pulse_stop();
        wait_idle(100);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
